// File: rtl/png_ttl_pkg.sv
// png_ttl_pkg: shared constants and helpers for the Pong TTL-style counter cells.
// Latency: n/a (package). Backpressure: n/a.
// Contents: direction constants and the terminal-value function.
// Optional feature macro: PNG_CNT_UPDOWN_EN, consumed by png_sync_counter.
package png_ttl_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Terminal value for a count of length `modulus`: MODULUS-1 counting up,
  // 0 counting down. Returned at the maximum supported width (16 bits);
  // callers truncate to their own WIDTH.
  function automatic logic [15:0] tc_value(input int modulus, input logic dir);
    logic [15:0] term;
    term = (dir == CNT_UP) ? 16'(modulus - 1) : 16'd0;
    return term;
  endfunction

endpackage

// File: rtl/png_sync_counter_if.sv
// png_sync_counter_if: control and data bundle of one counter cell.
// Latency: n/a (wires only). Backpressure: none; the cell accepts every cycle.
// Ports: _load/d/en_p/en_t/up_dn driven by master, q/carry driven by slave.
interface png_sync_counter_if #(
  parameter int WIDTH = 4
);

  logic             _load;  // parallel load, active-low
  logic [WIDTH-1:0] d;      // parallel load data
  logic             en_p;   // count enable P (does not gate carry)
  logic             en_t;   // count enable T (gates carry)
  logic             up_dn;  // 1 = up, 0 = down
  logic [WIDTH-1:0] q;      // registered count
  logic             carry;  // combinational ripple carry/borrow

  modport master (
    output _load, d, en_p, en_t, up_dn,
    input  q, carry
  );

  modport slave (
    input  _load, d, en_p, en_t, up_dn,
    output q, carry
  );

endinterface

// File: rtl/png_tc_decode.sv
// png_tc_decode: terminal-state comparator for a WIDTH-bit modulo-MODULUS count.
// Latency: combinational. Backpressure: none.
// Ports: q/dir in; tc = q at exact terminal value, wrap = next step must wrap.
module png_tc_decode
  import png_ttl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] term;

  assign term = WIDTH'(tc_value(MODULUS, dir));
  assign tc   = (q == term);

  // Counting up, any value at or beyond the top (e.g. an out-of-range load)
  // wraps to 0. Counting down, only 0 wraps; larger values just decrement.
  assign wrap = (dir == CNT_UP) ? (q >= TOP) : tc;

endmodule

// File: rtl/png_sync_counter.sv
// png_sync_counter: synchronous modulo-N counter with load, P/T enables, ripple carry.
// Latency: 1 clock for clear/load/count; carry is combinational (0 clocks).
// Backpressure: none; en_p/en_t gate counting, carry feeds the next stage's en_t.
// Ports: clk, clr (sync active-high), bus (slave modport of png_sync_counter_if).
// Option: define PNG_CNT_UPDOWN_EN to honour up_dn; otherwise up-only.
module png_sync_counter
  import png_ttl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic                  clk,
  input  logic                  clr,
  png_sync_counter_if.slave     bus
);

  // Elaboration-time parameter legality.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("png_sync_counter: WIDTH must be 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("png_sync_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] step_val;
  logic             dir;
  logic             tc;
  logic             wrap;

`ifdef PNG_CNT_UPDOWN_EN
  assign dir = bus.up_dn;
`else
  // Up-only build: direction is fixed, so the down decode folds away.
  logic unused_up_dn;
  assign dir          = CNT_UP;
  assign unused_up_dn = bus.up_dn;
`endif

  png_tc_decode #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc_decode (
    .q    (q_r),
    .dir  (dir),
    .tc   (tc),
    .wrap (wrap)
  );

  // One count step in the current direction.
  always_comb begin
    step_val = wrap ? '0 : q_r + WIDTH'(1);
`ifdef PNG_CNT_UPDOWN_EN
    if (dir == CNT_DN) begin
      step_val = wrap ? TOP : q_r - WIDTH'(1);
    end
`endif
  end

  // Priority: clear, then load, then count, else hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_r <= '0;
    end else if (!bus._load) begin
      q_r <= bus.d;
    end else if (bus.en_p && bus.en_t) begin
      q_r <= step_val;
    end
  end

  assign bus.q     = q_r;
  // Carry ignores en_p, _load and clr so cascaded stages see it immediately.
  assign bus.carry = bus.en_t & tc;

endmodule

// File: tb/tb_png_sync_counter.sv
// tb_png_sync_counter: directed bench for png_sync_counter.
// Instances: M16 (reset/hold), M10 (wrap/load/reset), two cascaded M16, M12 (direction).
module tb_png_sync_counter;

  logic clk;
  logic clr;
  int   n_pass;
  int   n_total;

  png_sync_counter_if #(.WIDTH(4)) if16 ();
  png_sync_counter_if #(.WIDTH(4)) if10 ();
  png_sync_counter_if #(.WIDTH(4)) if12 ();
  png_sync_counter_if #(.WIDTH(4)) if_lo ();
  png_sync_counter_if #(.WIDTH(4)) if_hi ();

  png_sync_counter #(.WIDTH(4), .MODULUS(16)) u_c16 (.clk(clk), .clr(clr), .bus(if16));
  png_sync_counter #(.WIDTH(4), .MODULUS(10)) u_c10 (.clk(clk), .clr(clr), .bus(if10));
  png_sync_counter #(.WIDTH(4), .MODULUS(12)) u_c12 (.clk(clk), .clr(clr), .bus(if12));
  png_sync_counter #(.WIDTH(4), .MODULUS(16)) u_lo  (.clk(clk), .clr(clr), .bus(if_lo));
  png_sync_counter #(.WIDTH(4), .MODULUS(16)) u_hi  (.clk(clk), .clr(clr), .bus(if_hi));

  // Cascade wiring: high stage shares controls, takes en_t from low carry.
  assign if_hi.en_t  = if_lo.carry;
  assign if_hi.en_p  = if_lo.en_p;
  assign if_hi._load = if_lo._load;
  assign if_hi.up_dn = if_lo.up_dn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    if16._load = 1'b1; if16.d = '0; if16.en_p = 1'b0; if16.en_t = 1'b0; if16.up_dn = 1'b1;
    if10._load = 1'b1; if10.d = '0; if10.en_p = 1'b0; if10.en_t = 1'b0; if10.up_dn = 1'b1;
    if12._load = 1'b1; if12.d = '0; if12.en_p = 1'b0; if12.en_t = 1'b0; if12.up_dn = 1'b1;
    if_lo._load = 1'b1; if_lo.d = '0; if_lo.en_p = 1'b0; if_lo.en_t = 1'b0; if_lo.up_dn = 1'b1;
    if_hi.d = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++;
      if (if16.q !== 4'd0) $display("FAIL reset_q cyc%0d: got %0d want 0", i, if16.q);
      else n_pass++;
    end
    clr = 1'b0;
    if16.en_p = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++;
      if (if16.q !== 4'd0) $display("FAIL hold_q cyc%0d: got %0d want 0", i, if16.q);
      else n_pass++;
      n_total++;
      if (if16.carry !== 1'b0) $display("FAIL hold_carry cyc%0d: got %b want 0", i, if16.carry);
      else n_pass++;
    end
    if16.en_p = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_q;
    if10.en_p = 1'b1;
    if10.en_t = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      exp_q = 4'(i % 10);
      n_total++;
      if (if10.q !== exp_q) $display("FAIL wrap_q i%0d: got %0d want %0d", i, if10.q, exp_q);
      else n_pass++;
      n_total++;
      if (if10.carry !== (exp_q == 4'd9))
        $display("FAIL wrap_carry i%0d: got %b want %b", i, if10.carry, (exp_q == 4'd9));
      else n_pass++;
      step();
    end
    // q is now 2; advance to 9.
    for (int i = 0; i < 7; i++) step();
    n_total++;
    if (if10.carry !== 1'b1) $display("FAIL carry_at9: got %b want 1", if10.carry);
    else n_pass++;
    if10.en_t = 1'b0;
    #1;
    n_total++;
    if (if10.carry !== 1'b0) $display("FAIL carry_drop: got %b want 0", if10.carry);
    else n_pass++;
    step();
    n_total++;
    if (if10.q !== 4'd9) $display("FAIL hold_at9: got %0d want 9", if10.q);
    else n_pass++;
    if10.en_p = 1'b0;
  endtask

  task automatic test_load();
    if10._load = 1'b0;
    if10.d     = 4'd13;
    if10.en_p  = 1'b1;
    if10.en_t  = 1'b1;
    step();
    n_total++;
    if (if10.q !== 4'd13) $display("FAIL load_13: got %0d want 13", if10.q);
    else n_pass++;
    n_total++;
    if (if10.carry !== 1'b0) $display("FAIL carry_oor: got %b want 0", if10.carry);
    else n_pass++;
    if10._load = 1'b1;
    step();
    n_total++;
    if (if10.q !== 4'd0) $display("FAIL oor_recover: got %0d want 0", if10.q);
    else n_pass++;
    if10.en_p = 1'b0;
    if10.en_t = 1'b0;
  endtask

  task automatic test_cascade();
    if_lo._load = 1'b0;
    if_lo.d     = 4'hF;
    if_hi.d     = 4'h0;
    step();
    n_total++;
    if ({if_hi.q, if_lo.q} !== 8'h0F) $display("FAIL casc_load: got %h want 0f", {if_hi.q, if_lo.q});
    else n_pass++;
    n_total++;
    if (if_lo.carry !== 1'b0) $display("FAIL casc_carry_ent0: got %b want 0", if_lo.carry);
    else n_pass++;
    if_lo._load = 1'b1;
    if_lo.en_p  = 1'b1;
    if_lo.en_t  = 1'b1;
    #1;
    n_total++;
    if (if_lo.carry !== 1'b1) $display("FAIL casc_carry15: got %b want 1", if_lo.carry);
    else n_pass++;
    step();
    n_total++;
    if ({if_hi.q, if_lo.q} !== 8'h10) $display("FAIL casc_count: got %h want 10", {if_hi.q, if_lo.q});
    else n_pass++;
    n_total++;
    if (if_lo.carry !== 1'b0) $display("FAIL casc_carry0: got %b want 0", if_lo.carry);
    else n_pass++;
    if_lo.en_p = 1'b0;
    if_lo.en_t = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    // if10 starts at 0 from the previous test.
    if10.en_p = 1'b1;
    if10.en_t = 1'b1;
    for (int i = 0; i < 7; i++) step();
    n_total++;
    if (if10.q !== 4'd7) $display("FAIL mid_count7: got %0d want 7", if10.q);
    else n_pass++;
    clr        = 1'b1;
    if10._load = 1'b0;
    if10.d     = 4'd5;
    step();
    n_total++;
    if (if10.q !== 4'd0) $display("FAIL clr_over_load: got %0d want 0", if10.q);
    else n_pass++;
    clr        = 1'b0;
    if10._load = 1'b1;
    step();
    n_total++;
    if (if10.q !== 4'd1) $display("FAIL resume_after_clr: got %0d want 1", if10.q);
    else n_pass++;
    if10.en_p = 1'b0;
    if10.en_t = 1'b0;
  endtask

  task automatic test_direction();
    if12._load = 1'b0;
    if12.d     = 4'd1;
    step();
    n_total++;
    if (if12.q !== 4'd1) $display("FAIL dir_load1: got %0d want 1", if12.q);
    else n_pass++;
    if12._load = 1'b1;
    if12.up_dn = 1'b0;
    if12.en_p  = 1'b1;
    if12.en_t  = 1'b1;
`ifdef PNG_CNT_UPDOWN_EN
    begin
      logic [3:0] exp_q [3];
      exp_q[0] = 4'd0; exp_q[1] = 4'd11; exp_q[2] = 4'd10;
      for (int i = 0; i < 3; i++) begin
        step();
        n_total++;
        if (if12.q !== exp_q[i]) $display("FAIL down_q i%0d: got %0d want %0d", i, if12.q, exp_q[i]);
        else n_pass++;
        n_total++;
        if (if12.carry !== (exp_q[i] == 4'd0))
          $display("FAIL down_carry i%0d: got %b want %b", i, if12.carry, (exp_q[i] == 4'd0));
        else n_pass++;
      end
      // Back to q=0, then drop en_t: borrow must vanish.
      if12._load = 1'b0;
      if12.d     = 4'd0;
      step();
      if12._load = 1'b1;
      if12.en_t  = 1'b0;
      #1;
      n_total++;
      if (if12.carry !== 1'b0) $display("FAIL down_carry_ent0: got %b want 0", if12.carry);
      else n_pass++;
    end
`else
    // up_dn is ignored: the counter still counts up.
    step();
    n_total++;
    if (if12.q !== 4'd2) $display("FAIL updn_ignored: got %0d want 2", if12.q);
    else n_pass++;
`endif
    if12.en_p  = 1'b0;
    if12.en_t  = 1'b0;
    if12.up_dn = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    clr     = 1'b1;
    test_reset();
    test_wrap();
    test_load();
    test_cascade();
    test_reset_mid_count();
    test_direction();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/png_sync_counter.md
# png_sync_counter

Parametrised synchronous binary/modulo-N counter, the generalised successor to the 4-bit TTL counter cells used throughout the Pong video timing and motion logic. Provides parallel load, P/T count enables, and a combinational ripple-carry output for cascading, at configurable width and modulus. An optional down-count mode is available for the motion counters. All state changes occur on the rising edge of `clk`; a chain of instances forms a wider counter exactly as cascaded TTL parts do.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits, 1..16.
- `MODULUS`, 2**WIDTH: count length. Must satisfy 2 ≤ MODULUS ≤ 2**WIDTH. The terminal count is MODULUS-1.

Ports:
- `clk`  in  1  system clock; all state changes occur on its rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `_load`  in  1  parallel load, active-low, synchronous.
- `d`  in  WIDTH  parallel load data.
- `en_p`  in  1  count enable P; does not gate `carry`.
- `en_t`  in  1  count enable T; gates `carry`.
- `up_dn`  in  1  direction: 1 = up, 0 = down. Ignored unless `PNG_CNT_UPDOWN_EN` is defined.
- `q`  out  WIDTH  count value, registered.
- `carry`  out  1  ripple carry/borrow, combinational: `en_t` AND terminal state.

## Operation
- The reset value is `q` = 0. `carry` follows its combinational definition below and therefore reads 0 while `en_t` = 0.
- Per-edge priority, highest first:
  - `clr` = 1: `q` ← 0.
  - `_load` = 0: `q` ← `d`. The enables are ignored.
  - `en_p` AND `en_t`: count one step.
  - Otherwise: hold.
- Up step:
  - If `q` ≥ MODULUS-1: `q` ← 0.
  - Else: `q` ← `q`+1.
  - An out-of-range loaded value therefore recovers to 0 on the next count.
- Down step (macro enabled only):
  - If `q` = 0: `q` ← MODULUS-1.
  - Else: `q` ← `q`-1. An out-of-range value counts down normally into range.
- Terminal state:
  - Up mode: `q` = MODULUS-1.
  - Down mode: `q` = 0.
- `carry` = `en_t` AND terminal state. It is independent of `en_p`, `_load` and `clr`.
- All arithmetic is WIDTH bits unsigned. No intermediate result exceeds WIDTH bits.
- `d` is loaded verbatim, including values ≥ MODULUS. No clamping is applied.
- Cascade rule:
  - Stage k+1 takes `en_t` = `carry` of stage k.
  - All stages share `en_p`, `_load` and `clr`.

## Timing
- Count, load and reset latency: 1 clock. The new `q` is visible after the rising edge.
- `carry` has zero latency from `q`, `en_t` and `up_dn`. It is a purely combinational path with no register.
- `up_dn` changed in the same cycle as a count: the new direction governs both that step and the `carry` decode.
- `clr` asserted during a load or count: reset wins, and `q` = 0 on the next cycle.
- `clr` deasserts: counting resumes on the first edge at which `clr` = 0.
- `_load` = 0 together with `en_p` = `en_t` = 1: the load wins. No increment is applied on that edge.

## Configuration
- `PNG_CNT_UPDOWN_EN` defined:
  - `up_dn` selects the count direction.
  - Down steps and the down-mode terminal decode are implemented.
- `PNG_CNT_UPDOWN_EN` undefined:
  - `up_dn` is ignored, and the counter is up-only.
  - The terminal state is always MODULUS-1.
  - No down-path logic is synthesised.

## Structure
- Shared package `png_ttl_pkg`:
  - Direction constants `CNT_UP` = 1'b1 and `CNT_DN` = 1'b0.
  - A function computing the terminal value from MODULUS and direction.
- One sub-module, `png_tc_decode`: WIDTH/MODULUS-parameterised terminal-state comparator producing the raw terminal flag. It is reused by the next-state logic and by `carry`.
- The top level holds the `q` register and the priority mux.
- Parameter legality is checked by elaboration-time assertion.

## Test plan
- Reset and hold:
  - Stimulus: WIDTH=4, MODULUS=16. `clr` = 1 for 2 cycles, then `en_p` = 1, `en_t` = 0 for 5 cycles.
  - Required: `q` = 0 throughout, `carry` = 0.
- Modulo wrap with carry:
  - Stimulus: WIDTH=4, MODULUS=10, up, both enables high for 12 cycles.
  - Required: `q` = 0..9, 0, 1. `carry` = 1 only while `q` = 9.
  - Stimulus: drop `en_t` at `q` = 9.
  - Required: `carry` → 0 in the same cycle, and `q` holds at 9.
- Load priority and out-of-range recovery:
  - Stimulus: MODULUS=10, `_load` = 0 with `d` = 13 and both enables high.
  - Required: `q` = 13 next cycle with no increment. The following count gives `q` = 0.
- Cascade:
  - Stimulus: two WIDTH=4 instances, low `carry` into high `en_t`, preload 0x0F, count once.
  - Required: combined value 0x10. Low `carry` = 1 only at low `q` = 15.
- Reset mid-count:
  - Stimulus: count to 7, then assert `clr` in the same cycle as `_load` = 0 with `d` = 5.
  - Required: `q` = 0. Deassert `clr` and count once: `q` = 1.
- Down mode (macro defined only):
  - Stimulus: MODULUS=12, `up_dn` = 0 from `q` = 1, count 3 steps.
  - Required: `q` = 0, 11, 10. `carry` = 1 only at `q` = 0 with `en_t` = 1.
